mem_wb_elastic: RTL and testbench

//  Parametrised MEM->WB pipeline register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/mem_wb_elastic_pkg.sv | 20 ++
 rtl/mem_wb_elastic_wb_pipe_slot.sv | 23 ++
 rtl/mem_wb_elastic.sv | 126 ++++++++++++
 tb/tb_mem_wb_elastic.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_elastic_pkg.sv
// Shared constants and state encoding for the MEM->WB elastic pipeline register.
// Optional retire counter is enabled by defining MEMWB_RETIRE_CNT_EN.
package mem_wb_elastic_pkg;

  typedef enum logic [1:0] {
    MEMWB_EMPTY = 2'd0,
    MEMWB_HALF  = 2'd1,
    MEMWB_FULL  = 2'd2
  } memwb_state_e;

  localparam logic RST_ENABLE    = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  // Packed payload: {wd, wreg, wdata, hi, lo, whilo}
  function automatic int payload_w(input int data_w, input int addr_w);
    return addr_w + 3 * data_w + 2;
  endfunction

endpackage

// File: rtl/mem_wb_elastic_wb_pipe_slot.sv
// One payload register of the MEM->WB skid buffer: load enable, async active-low reset to zero.
// Reset value zero doubles as NOP register address, write-disable and zero word.
module wb_pipe_slot
  import mem_wb_elastic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_elastic.sv
// MEM->WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Define MEMWB_RETIRE_CNT_EN to add the wb_retire_cnt drain counter.
module mem_wb_elastic
  import mem_wb_elastic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
`ifdef MEMWB_RETIRE_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              mem_whilo,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic              wb_whilo
`ifdef MEMWB_RETIRE_CNT_EN
  , output logic [CNT_W-1:0] wb_retire_cnt
`endif
);

  localparam int PW = payload_w(DATA_W, ADDR_W);

  memwb_state_e state, state_next;
  logic accept, drain;
  logic load_main, load_skid, main_from_skid;
  logic [PW-1:0] in_payload, main_d, main_q, skid_q;
  logic wreg_q, whilo_q;

  assign accept = mem_valid & mem_ready;
  assign drain  = wb_valid & wb_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state <= MEMWB_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // flush wins over everything; a same-cycle drain still counts as delivered
  always_comb begin
    state_next = state;
    unique case (state)
      MEMWB_EMPTY: if (accept) state_next = MEMWB_HALF;
      MEMWB_HALF: begin
        if (accept && !drain)      state_next = MEMWB_FULL;
        else if (drain && !accept) state_next = MEMWB_EMPTY;
      end
      MEMWB_FULL: if (drain) state_next = MEMWB_HALF;
      default:    state_next = MEMWB_EMPTY;
    endcase
    if (flush) state_next = MEMWB_EMPTY;
  end

  // mem_ready depends on registered state only, so wb_ready never reaches it combinationally
  always_comb begin
    mem_ready      = (state != MEMWB_FULL);
    wb_valid       = (state != MEMWB_EMPTY);
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (!flush) begin
      unique case (state)
        MEMWB_EMPTY: load_main = accept;
        MEMWB_HALF: begin
          load_main = accept & drain;
          load_skid = accept & ~drain;
        end
        MEMWB_FULL: begin
          load_main      = drain;
          main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_payload = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo};
  assign main_d     = main_from_skid ? skid_q : in_payload;

  wb_pipe_slot #(.W(PW)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (load_main),
    .d    (main_d),
    .q    (main_q)
  );

  wb_pipe_slot #(.W(PW)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (load_skid),
    .d    (in_payload),
    .q    (skid_q)
  );

  assign {wb_wd, wreg_q, wb_wdata, wb_hi, wb_lo, whilo_q} = main_q;
  assign wb_wreg  = wb_valid ? wreg_q  : WRITE_DISABLE;
  assign wb_whilo = wb_valid ? whilo_q : WRITE_DISABLE;

`ifdef MEMWB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      wb_retire_cnt <= '0;
    end else if (drain) begin
      wb_retire_cnt <= wb_retire_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Self-checking bench for mem_wb_elastic against a queue-based FIFO model.
// Retire counter checks are included when MEMWB_RETIRE_CNT_EN is defined (counter built 4 bits wide).
module tb_mem_wb_elastic;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_wd = '0;
  logic        mem_wreg = 1'b0;
  logic [31:0] mem_wdata = '0, mem_hi = '0, mem_lo = '0;
  logic        mem_whilo = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata, wb_hi, wb_lo;
  logic        wb_whilo;
`ifdef MEMWB_RETIRE_CNT_EN
  logic [3:0]  wb_retire_cnt;
`endif

  beat_t model_q[$];
  int    cnt_model = 0;
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  mem_wb_elastic #(
    .DATA_W(32),
    .ADDR_W(5)
`ifdef MEMWB_RETIRE_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_whilo (mem_whilo),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .wb_hi     (wb_hi),
    .wb_lo     (wb_lo),
    .wb_whilo  (wb_whilo)
`ifdef MEMWB_RETIRE_CNT_EN
    , .wb_retire_cnt (wb_retire_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic beat_t makeBeat(input int wd, input int wdata);
    beat_t b;
    b.wd    = 5'(wd);
    b.wreg  = 1'b1;
    b.wdata = 32'(wdata);
    b.hi    = '0;
    b.lo    = '0;
    b.whilo = 1'b0;
    return b;
  endfunction

  function automatic beat_t randBeat();
    beat_t b;
    b.wd    = 5'($urandom);
    b.wreg  = 1'($urandom);
    b.wdata = $urandom;
    b.hi    = $urandom;
    b.lo    = $urandom;
    b.whilo = 1'($urandom);
    return b;
  endfunction

  // Expected outputs follow from the model FIFO occupancy (at most two beats held)
  task automatic compareAll(input string tag);
    checkOutput({tag, "_ready"}, 64'(mem_ready), 64'(model_q.size() < 2));
    checkOutput({tag, "_valid"}, 64'(wb_valid), 64'(model_q.size() > 0));
    if (model_q.size() > 0) begin
      checkOutput({tag, "_wd"},    64'(wb_wd),    64'(model_q[0].wd));
      checkOutput({tag, "_wreg"},  64'(wb_wreg),  64'(model_q[0].wreg));
      checkOutput({tag, "_wdata"}, 64'(wb_wdata), 64'(model_q[0].wdata));
      checkOutput({tag, "_hi"},    64'(wb_hi),    64'(model_q[0].hi));
      checkOutput({tag, "_lo"},    64'(wb_lo),    64'(model_q[0].lo));
      checkOutput({tag, "_whilo"}, 64'(wb_whilo), 64'(model_q[0].whilo));
    end else begin
      checkOutput({tag, "_wreg"},  64'(wb_wreg),  64'd0);
      checkOutput({tag, "_whilo"}, 64'(wb_whilo), 64'd0);
    end
`ifdef MEMWB_RETIRE_CNT_EN
    checkOutput({tag, "_cnt"}, 64'(wb_retire_cnt), 64'(cnt_model));
`endif
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"}, 64'(wb_valid), 64'd0);
    checkOutput({tag, "_wd"},    64'(wb_wd),    64'd0);
    checkOutput({tag, "_wreg"},  64'(wb_wreg),  64'd0);
    checkOutput({tag, "_wdata"}, 64'(wb_wdata), 64'd0);
    checkOutput({tag, "_hi"},    64'(wb_hi),    64'd0);
    checkOutput({tag, "_lo"},    64'(wb_lo),    64'd0);
    checkOutput({tag, "_whilo"}, 64'(wb_whilo), 64'd0);
`ifdef MEMWB_RETIRE_CNT_EN
    checkOutput({tag, "_cnt"}, 64'(wb_retire_cnt), 64'd0);
`endif
  endtask

  // Called just after a falling edge: drive, advance the model at the rising edge, check at the next falling edge
  task automatic applyStimulus(input logic v, input beat_t b, input logic rdy, input logic fl, input string tag);
    bit acc, drn;
    mem_valid = v;
    mem_wd    = b.wd;
    mem_wreg  = b.wreg;
    mem_wdata = b.wdata;
    mem_hi    = b.hi;
    mem_lo    = b.lo;
    mem_whilo = b.whilo;
    wb_ready  = rdy;
    flush     = fl;
    @(posedge clk);
    acc = v && (model_q.size() < 2);
    drn = rdy && (model_q.size() > 0);
    if (drn) begin
      void'(model_q.pop_front());
      cnt_model = (cnt_model + 1) % 16;
    end
    if (fl) model_q.delete();
    else if (acc) model_q.push_back(b);
    @(negedge clk);
    compareAll(tag);
  endtask

  task automatic doReset(input string tag);
    mem_valid = 1'b0;
    wb_ready  = 1'b0;
    flush     = 1'b0;
    rst       = 1'b0;
    model_q.delete();
    cnt_model = 0;
    repeat (2) @(negedge clk);
    checkReset(tag);
    rst = 1'b1;
    compareAll({tag, "_rel"});
  endtask

  beat_t nb;

  initial begin
    nb = '0;
    @(negedge clk);
    doReset("rst0");

    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, makeBeat(i, i * 17), 1'b1, 1'b0, "b2b");
    applyStimulus(1'b0, nb, 1'b1, 1'b0, "b2b_tail");

    applyStimulus(1'b1, makeBeat(5, 32'h55), 1'b0, 1'b0, "stall_half");
    applyStimulus(1'b1, makeBeat(6, 32'h66), 1'b0, 1'b0, "stall_full");
    applyStimulus(1'b1, makeBeat(7, 32'h77), 1'b1, 1'b0, "rel_main");
    applyStimulus(1'b1, makeBeat(7, 32'h77), 1'b1, 1'b0, "rel_skid");
    applyStimulus(1'b0, nb, 1'b1, 1'b0, "rel_tail");

    applyStimulus(1'b1, makeBeat(8, 32'h88), 1'b0, 1'b0, "fl_fill1");
    applyStimulus(1'b1, makeBeat(9, 32'h99), 1'b0, 1'b0, "fl_fill2");
    applyStimulus(1'b1, makeBeat(10, 32'hAA), 1'b0, 1'b1, "flush");
    applyStimulus(1'b0, nb, 1'b1, 1'b0, "fl_after");

    nb.wd = 5'd3; nb.wreg = 1'b0; nb.wdata = 32'h0; nb.whilo = 1'b1;
    nb.hi = 32'hDEADBEEF; nb.lo = 32'h12345678;
    applyStimulus(1'b1, nb, 1'b0, 1'b0, "hilo");
    applyStimulus(1'b0, nb, 1'b1, 1'b0, "hilo_drain");

    applyStimulus(1'b1, makeBeat(11, 32'hB1), 1'b0, 1'b0, "ar_fill1");
    applyStimulus(1'b1, makeBeat(12, 32'hB2), 1'b0, 1'b0, "ar_fill2");
    #2 rst = 1'b0;
    #1 checkReset("async_rst");
    model_q.delete();
    cnt_model = 0;
    mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    compareAll("ar_release");

    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), randBeat(), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 15) == 0), "rand");

`ifdef MEMWB_RETIRE_CNT_EN
    doReset("rst_cnt");
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, randBeat(), 1'b1, 1'b0, "cnt_run");
    applyStimulus(1'b0, nb, 1'b1, 1'b0, "cnt_last");
    checkOutput("cnt_wrap", 64'(wb_retire_cnt), 64'd1);
    applyStimulus(1'b1, randBeat(), 1'b0, 1'b0, "cnt_hold");
    applyStimulus(1'b1, randBeat(), 1'b0, 1'b1, "cnt_flush");
    checkOutput("cnt_after_flush", 64'(wb_retire_cnt), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
